// File: rtl/de_mem_responder_if.sv
// Drawing-engine memory request bus (de_req/de_ack handshake).
// The engine drives the master side; the memory responder sits on the slave side.
interface de_mem_responder_if #(
  parameter int ADDR_W = 18
);
  logic              de_req;
  logic              de_ack;
  logic [ADDR_W-1:0] de_addr;
  logic [3:0]        de_nbyte;
  logic              de_rnw;
  logic [31:0]       de_w_data;
  logic [31:0]       de_r_data;
  logic              de_err;

  modport master (
    output de_req, de_addr, de_nbyte, de_rnw, de_w_data,
    input  de_ack, de_r_data, de_err
  );

  modport slave (
    input  de_req, de_addr, de_nbyte, de_rnw, de_w_data,
    output de_ack, de_r_data, de_err
  );
endinterface

// File: rtl/de_mem_responder.sv
// Drawing-engine memory responder: one byte-masked read or write per handshake,
// performed on a shared single-port frame-store SRAM once the arbiter grants it.
//
//  state   | meaning
//  IDLE    | waiting for de_req, captures the request when it arrives
//  WAIT    | burning configured wait states before the RAM access
//  ACCESS  | waiting for ram_gnt, then issues the access (or flags out of range)
//  RDATA   | read issued, RAM data returns next cycle
//  ACK     | closes the transaction: pulses de_ack, lands read data
module de_mem_responder #(
  parameter int ADDR_W      = 18,
  parameter int DEPTH       = 76800,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  de_mem_responder_if.slave de,
  input  logic              ram_gnt,
  output logic              ram_cs,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_RDATA, S_ACK} state_t;

  localparam logic [31:0] DEPTH_C = 32'(DEPTH);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        nbyte_q, nbyte_d;
  logic              rnw_q, rnw_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              oob_q, oob_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              cs_q, cs_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [31:0]       rwdata_q, rwdata_d;

  logic              oob;
  logic [31:0]       byte_keep;

  assign oob       = (32'(addr_q) >= DEPTH_C);
  assign byte_keep = ~{{8{nbyte_q[3]}}, {8{nbyte_q[2]}}, {8{nbyte_q[1]}}, {8{nbyte_q[0]}}};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    nbyte_d  = nbyte_q;
    rnw_d    = rnw_q;
    wdata_d  = wdata_q;
    oob_d    = oob_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    cs_d     = 1'b0;
    we_d     = 4'b0000;
    raddr_d  = raddr_q;
    rwdata_d = rwdata_q;

    case (state_q)
      S_IDLE: begin
        if (de.de_req) begin
          addr_d  = de.de_addr;
          nbyte_d = de.de_nbyte;
          rnw_d   = de.de_rnw;
          wdata_d = de.de_w_data;
          if (WAIT_STATES > 0) begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = S_WAIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        if (ram_gnt) begin
          oob_d = oob;
          if (oob) begin
            state_d = S_ACK;
          end else if (!rnw_q) begin
            // A write with every byte masked still handshakes but skips the RAM.
            if (nbyte_q != 4'b1111) begin
              cs_d     = 1'b1;
              we_d     = ~nbyte_q;
              raddr_d  = addr_q;
              rwdata_d = wdata_q;
            end
            state_d = S_ACK;
          end else begin
            cs_d    = 1'b1;
            raddr_d = addr_q;
            state_d = S_RDATA;
          end
        end
      end
      S_RDATA: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        // RAM read data is valid now, so it lands together with the ack pulse.
        ack_d = 1'b1;
        err_d = oob_q;
        if (oob_q)      rdata_d = 32'h0;
        else if (rnw_q) rdata_d = ram_rdata & byte_keep;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      nbyte_q  <= 4'b0000;
      rnw_q    <= 1'b0;
      wdata_q  <= 32'h0;
      oob_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      cs_q     <= 1'b0;
      we_q     <= 4'b0000;
      raddr_q  <= '0;
      rwdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      nbyte_q  <= nbyte_d;
      rnw_q    <= rnw_d;
      wdata_q  <= wdata_d;
      oob_q    <= oob_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      raddr_q  <= raddr_d;
      rwdata_q <= rwdata_d;
    end
  end

  assign de.de_ack    = ack_q;
  assign de.de_err    = err_q;
  assign de.de_r_data = rdata_q;
  assign ram_cs       = cs_q;
  assign ram_we       = we_q;
  assign ram_addr     = raddr_q;
  assign ram_wdata    = rwdata_q;

endmodule

// File: tb/tb_de_mem_responder.sv
// Bench for de_mem_responder: directed and random transactions against a
// word/byte reference memory, plus a second instance built with two wait states.
module tb_de_mem_responder;
  localparam int DEPTH = 76800;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        gnt0, cs0, gnt2, cs2;
  logic [3:0]  we0, we2;
  logic [17:0] addr0, addr2;
  logic [31:0] wd0, rd0, wd2, rd2;

  de_mem_responder_if #(.ADDR_W(18)) bus0 ();
  de_mem_responder_if #(.ADDR_W(18)) bus2 ();

  de_mem_responder #(.ADDR_W(18), .DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .de(bus0), .ram_gnt(gnt0), .ram_cs(cs0),
    .ram_we(we0), .ram_addr(addr0), .ram_wdata(wd0), .ram_rdata(rd0));

  de_mem_responder #(.ADDR_W(18), .DEPTH(DEPTH), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .de(bus2), .ram_gnt(gnt2), .ram_cs(cs2),
    .ram_we(we2), .ram_addr(addr2), .ram_wdata(wd2), .ram_rdata(rd2));

  logic [31:0] mem0 [0:DEPTH-1];
  logic [31:0] mem2 [0:DEPTH-1];

  always @(posedge clk) begin
    if (cs0) begin
      if (we0 == 4'b0000) rd0 <= mem0[addr0];
      else for (int b = 0; b < 4; b++) if (we0[b]) mem0[addr0][8*b +: 8] <= wd0[8*b +: 8];
    end
    if (cs2) begin
      if (we2 == 4'b0000) rd2 <= mem2[addr2];
      else for (int b = 0; b < 4; b++) if (we2[b]) mem2[addr2][8*b +: 8] <= wd2[8*b +: 8];
    end
  end

  int          cs_cnt0 = 0, cs_cnt2 = 0;
  logic [3:0]  last_we0;
  logic [17:0] last_addr0;
  always @(negedge clk) begin
    if (cs0) begin
      cs_cnt0    <= cs_cnt0 + 1;
      last_we0   <= we0;
      last_addr0 <= addr0;
    end
    if (cs2) cs_cnt2 <= cs_cnt2 + 1;
  end

  // Reference memory: what each word should hold after the writes issued so far.
  logic [31:0] ref_m [int];

  function automatic logic [31:0] ref_rd(input int a);
    return ref_m.exists(a) ? ref_m[a] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] nb,
                                        input logic [31:0] wd);
    logic [31:0] w = old;
    for (int b = 0; b < 4; b++) if (!nb[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  function automatic logic [31:0] keep_bytes(input logic [31:0] v, input logic [3:0] nb);
    logic [31:0] w = v;
    for (int b = 0; b < 4; b++) if (nb[b]) w[8*b +: 8] = 8'h00;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on u0; req is dropped the moment the ack is seen.
  task automatic txn(input logic rnw, input logic [17:0] a, input logic [3:0] nb,
                     input logic [31:0] wd, input bit rand_gnt,
                     output logic [31:0] rd, output logic er, output int lat, output int ncs);
    int e, cs_start;
    bit got;
    cs_start = cs_cnt0;
    bus0.de_req = 1'b1; bus0.de_rnw = rnw; bus0.de_addr = a;
    bus0.de_nbyte = nb; bus0.de_w_data = wd;
    e = cyc + 1; got = 1'b0; lat = -1; rd = 'x; er = 1'bx;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk); #1;
      if (bus0.de_ack) begin
        got = 1'b1; lat = cyc - e; rd = bus0.de_r_data; er = bus0.de_err;
        bus0.de_req = 1'b0;
      end
      if (rand_gnt) gnt0 = (i > 20) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    chk("ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    chk("ack_width", 32'(bus0.de_ack), 32'd0);
    ncs = cs_cnt0 - cs_start;
    gnt0 = 1'b1;
  endtask

  task automatic ref_txn(input logic rnw, input logic [17:0] a, input logic [3:0] nb,
                         input logic [31:0] wd, input bit rand_gnt, input string tag);
    logic [31:0] rd, exp_rd;
    logic er;
    int lat, ncs, exp_cs, exp_lat;
    bit oob = (int'(a) >= DEPTH);
    exp_rd = 32'h0;
    if (oob)       exp_cs = 0;
    else if (rnw)  begin exp_cs = 1; exp_rd = keep_bytes(ref_rd(int'(a)), nb); end
    else           begin exp_cs = (nb != 4'b1111) ? 1 : 0;
                         ref_m[int'(a)] = merge(ref_rd(int'(a)), nb, wd); end
    exp_lat = (rnw && !oob) ? 3 : 2;
    txn(rnw, a, nb, wd, rand_gnt, rd, er, lat, ncs);
    chk({tag, "_err"}, 32'(er), 32'(oob));
    chk({tag, "_ncs"}, 32'(ncs), 32'(exp_cs));
    if (rnw || oob) chk({tag, "_rdata"}, rd, exp_rd);
    if (!rand_gnt)  chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic [31:0] rd, cur_wd;
    logic [3:0]  cur_nb;
    logic        er;
    int lat, ncs, e, prev, exp_cs, cs_start;
    bit got, gprev;

    for (int i = 0; i < DEPTH; i++) begin mem0[i] = 32'h0; mem2[i] = 32'h0; end
    rst_n = 1'b0; gnt0 = 1'b1; gnt2 = 1'b1;
    bus0.de_req = 1'b0; bus0.de_rnw = 1'b0; bus0.de_addr = '0; bus0.de_nbyte = 4'h0; bus0.de_w_data = '0;
    bus2.de_req = 1'b0; bus2.de_rnw = 1'b0; bus2.de_addr = '0; bus2.de_nbyte = 4'h0; bus2.de_w_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus0.de_ack), 32'd0);
    chk("rst_err", 32'(bus0.de_err), 32'd0);
    chk("rst_rdata", bus0.de_r_data, 32'h0);
    chk("rst_cs", 32'({cs0, we0, cs2, we2}), 32'd0);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_wdata", wd0, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill, partial write of byte 0, read back.
    ref_txn(1'b0, 18'h00010, 4'b0000, 32'h11223344, 1'b0, "fill");
    ref_txn(1'b0, 18'h00010, 4'b1110, 32'hAABBCCDD, 1'b0, "wr_byte0");
    chk("wr_byte0_we", 32'(last_we0), 32'h1);
    chk("wr_byte0_addr", 32'(last_addr0), 32'h10);
    chk("wr_byte0_mem", mem0[16], 32'h112233DD);
    ref_txn(1'b1, 18'h00010, 4'b0000, 32'h0, 1'b0, "rd_back");
    ref_txn(1'b1, 18'h00010, 4'b1111, 32'h0, 1'b0, "rd_nomask");
    ref_txn(1'b0, 18'h00011, 4'b1111, 32'hFFFFFFFF, 1'b0, "wr_nobytes");

    // Out of range on both sides of the boundary.
    ref_txn(1'b0, 18'(DEPTH), 4'b0000, 32'h12345678, 1'b0, "oob_wr");
    ref_txn(1'b1, 18'(DEPTH + 1), 4'b0000, 32'h0, 1'b0, "oob_rd");
    ref_txn(1'b0, 18'(DEPTH - 1), 4'b0000, 32'h0BADBEEF, 1'b0, "last_wr");
    ref_txn(1'b1, 18'(DEPTH - 1), 4'b0000, 32'h0, 1'b0, "last_rd");

    // Reset while the read is in RDATA: everything clears and no ack follows.
    ref_txn(1'b1, 18'h00010, 4'b0000, 32'h0, 1'b0, "pre_rst_rd");
    bus0.de_req = 1'b1; bus0.de_rnw = 1'b1; bus0.de_addr = 18'h00010; bus0.de_nbyte = 4'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("mid_rd_cs", 32'(cs0), 32'd1);
    rst_n = 1'b0; bus0.de_req = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(bus0.de_ack), 32'd0);
    chk("mid_rst_rdata", bus0.de_r_data, 32'h0);
    chk("mid_rst_ram", 32'({cs0, we0}), 32'd0);
    chk("mid_rst_addr", 32'(addr0), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    got = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (bus0.de_ack) got = 1'b1; end
    chk("no_ack_after_rst", 32'(got), 32'd0);

    // Random transactions with a randomly toggling grant.
    for (int n = 0; n < 40; n++) begin
      logic [17:0] a;
      a = ($urandom_range(0, 9) == 0) ? 18'(DEPTH + $urandom_range(0, 3)) : 18'($urandom_range(0, 31));
      ref_txn(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, 1'b1, "rand");
    end

    // Engine-style stream: req held high, next request presented as each ack arrives.
    cs_start = cs_cnt0; exp_cs = 0; gnt0 = 1'b1;
    cur_nb = 4'($urandom_range(0, 15)); cur_wd = $urandom;
    bus0.de_rnw = 1'b0; bus0.de_addr = 18'd1000; bus0.de_nbyte = cur_nb; bus0.de_w_data = cur_wd;
    bus0.de_req = 1'b1; prev = cyc;
    for (int n = 0; n < 640; n++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin @(posedge clk); #1; got = bus0.de_ack; end
      chk("stream_ack", 32'(got), 32'd1);
      chk("stream_gap", 32'(cyc - prev), 32'd3);
      prev = cyc;
      ref_m[1000 + n] = merge(ref_rd(1000 + n), cur_nb, cur_wd);
      if (cur_nb != 4'b1111) exp_cs++;
      if (n < 639) begin
        cur_nb = 4'($urandom_range(0, 15)); cur_wd = $urandom;
        bus0.de_addr = 18'(1001 + n); bus0.de_nbyte = cur_nb; bus0.de_w_data = cur_wd;
      end else begin
        bus0.de_req = 1'b0;
      end
    end
    repeat (4) @(posedge clk);
    #1;
    chk("stream_ncs", 32'(cs_cnt0 - cs_start), 32'(exp_cs));
    for (int n = 0; n < 640; n++) chk("stream_mem", mem0[1000 + n], ref_rd(1000 + n));
    for (int a = 0; a < 32; a++) chk("rand_mem", mem0[a], ref_rd(a));

    // Two wait states plus five grant-low cycles in ACCESS.
    gnt2 = 1'b0; gprev = 1'b0; cs_start = cs_cnt2;
    bus2.de_req = 1'b1; bus2.de_rnw = 1'b0; bus2.de_addr = 18'd5;
    bus2.de_nbyte = 4'b0000; bus2.de_w_data = 32'hCAFEF00D;
    e = cyc + 1; got = 1'b0; lat = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (!gprev) chk("cs_while_gnt_low", 32'(cs2), 32'd0);
      if (bus2.de_ack) begin got = 1'b1; lat = cyc - e; bus2.de_req = 1'b0; end
      gnt2 = (cyc >= e + 7);
      gprev = gnt2;
    end
    chk("ws_ack_seen", 32'(got), 32'd1);
    chk("ws_wr_lat", 32'(lat), 32'd9);
    @(posedge clk); #1;
    chk("ws_ack_width", 32'(bus2.de_ack), 32'd0);
    chk("ws_ncs", 32'(cs_cnt2 - cs_start), 32'd1);
    chk("ws_mem", mem2[5], 32'hCAFEF00D);

    gnt2 = 1'b1;
    bus2.de_req = 1'b1; bus2.de_rnw = 1'b1; bus2.de_nbyte = 4'b0011;
    e = cyc + 1; got = 1'b0; lat = -1; rd = 'x;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (bus2.de_ack) begin got = 1'b1; lat = cyc - e; rd = bus2.de_r_data; bus2.de_req = 1'b0; end
    end
    chk("ws_rd_seen", 32'(got), 32'd1);
    chk("ws_rd_lat", 32'(lat), 32'd5);
    chk("ws_rd_data", rd, 32'hCAFE0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
